// File: rtl/dbus_wb_bridge.sv
// Bridges a single-cycle-strobe core data bus onto a Wishbone classic master port.
// One transfer in flight at a time; errors, timeouts and overruns latch a sticky flag.
module dbus_wb_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dbus_adr,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [15:0] dbus_dat_o,
  output logic [15:0] dbus_dat_i,
  output logic        dbus_busy,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [1:0]  wb_sel_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        err_o,
  input  logic        err_clr
);

  typedef enum logic {IDLE, BUS} state_t;

  // Last counter value before a silent slave is forcibly terminated.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [15:0] adr_reg, adr_next;
  logic [15:0] wdat_reg, wdat_next;
  logic [15:0] rdat_reg, rdat_next;
  logic        err_reg, err_next;
  logic        set_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      rdat_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cyc_reg   <= cyc_next;
      we_reg    <= we_next;
      adr_reg   <= adr_next;
      wdat_reg  <= wdat_next;
      rdat_reg  <= rdat_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cyc_next   = cyc_reg;
    we_next    = we_reg;
    adr_next   = adr_reg;
    wdat_next  = wdat_reg;
    rdat_next  = rdat_reg;
    set_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dbus_re || dbus_we) begin
          state_next = BUS;
          cyc_next   = 1'b1;
          cnt_next   = '0;
          we_next    = dbus_we;
          adr_next   = dbus_adr;
          wdat_next  = dbus_dat_o;
          set_err    = dbus_re && dbus_we;
        end
      end
      BUS: begin
        // A new strobe while busy is an overrun, even on the terminating edge.
        if (dbus_re || dbus_we) set_err = 1'b1;
        if (wb_err_i || (!wb_ack_i && cnt_reg == CNT_LAST)) begin
          state_next = IDLE;
          cyc_next   = 1'b0;
          set_err    = 1'b1;
          if (!we_reg) rdat_next = ERR_DATA;
        end else if (wb_ack_i) begin
          state_next = IDLE;
          cyc_next   = 1'b0;
          if (!we_reg) rdat_next = wb_dat_i;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    err_next = set_err || (err_reg && !err_clr);
  end

  assign wb_cyc_o   = cyc_reg;
  assign wb_stb_o   = cyc_reg;
  assign dbus_busy  = cyc_reg;
  assign wb_we_o    = we_reg;
  assign wb_adr_o   = adr_reg;
  assign wb_dat_o   = wdat_reg;
  assign wb_sel_o   = 2'b11;
  assign dbus_dat_i = rdat_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// Transaction-level randomized bench for dbus_wb_bridge built with TIMEOUT=4.
module tb_dbus_wb_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dbus_adr, dbus_dat_o, dbus_dat_i;
  logic        dbus_re, dbus_we, dbus_busy;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, err_o, err_clr;

  int total = 0;
  int bad   = 0;
  logic        err_m;
  logic [15:0] rdat_m;

  dbus_wb_bridge #(.TIMEOUT(TO), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .reset(reset),
    .dbus_adr(dbus_adr), .dbus_re(dbus_re), .dbus_we(dbus_we),
    .dbus_dat_o(dbus_dat_o), .dbus_dat_i(dbus_dat_i), .dbus_busy(dbus_busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .err_o(err_o), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One core transfer; lat = cycle on which the slave terminates (beyond TO never happens),
  // ovr = BUS cycle in which a stray strobe is injected (0 = none).
  task automatic xfer(input logic [15:0] adr, input logic [15:0] dat, input bit is_wr,
                      input bit both, input int lat, input bit use_err, input int ovr,
                      input logic [15:0] rd);
    bit eff_wr   = is_wr || both;
    int exp_cyc  = (lat <= TO) ? lat : TO;
    bit term_err = (lat > TO) || use_err;
    bit ovr_hit  = (ovr >= 1) && (ovr <= exp_cyc);
    int cycles   = 0;
    dbus_adr   = adr;
    dbus_dat_o = dat;
    dbus_we    = eff_wr;
    dbus_re    = !is_wr;
    wb_dat_i   = rd;
    @(posedge clk); #1;
    dbus_re = 1'b0; dbus_we = 1'b0;
    dbus_adr = 16'($urandom); dbus_dat_o = 16'($urandom);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!wb_cyc_o) break;
      cycles++;
      chk("adr_hold", wb_adr_o, adr);
      chk("we_hold", wb_we_o, eff_wr);
      chk("wdat_hold", wb_dat_o, dat);
      chk("busy_hi", {dbus_busy, wb_stb_o}, 2'b11);
      chk("sel", wb_sel_o, 2'b11);
      if (k == lat) begin
        wb_err_i = use_err;
        wb_ack_i = use_err ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (k == ovr) begin
        if ($urandom_range(0, 1) == 1) dbus_we = 1'b1; else dbus_re = 1'b1;
      end
      @(posedge clk); #1;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0;
    end
    chk("cyc_count", cycles, exp_cyc);
    chk("busy_lo", {dbus_busy, wb_cyc_o}, 2'b00);
    err_m = err_m || both || term_err || ovr_hit;
    if (!eff_wr) rdat_m = term_err ? 16'hFFFF : rd;
    chk("rdata", dbus_dat_i, rdat_m);
    chk("err", err_o, err_m);
    $display("xfer adr=%h wr=%0d both=%0d lat=%0d err=%0d ovr=%0d cyc=%0d rdat=%h err_o=%0d",
             adr, is_wr, both, lat, use_err, ovr, cycles, dbus_dat_i, err_o);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    err_m = 1'b0;
    @(negedge clk);
    chk("err_clr", err_o, 1'b0);
    $display("err_clr pulse err_o=%0d", err_o);
  endtask

  initial begin
    reset = 1'b1; dbus_adr = '0; dbus_re = 0; dbus_we = 0; dbus_dat_o = '0;
    wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0; err_clr = 0;
    err_m = 1'b0; rdat_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, dbus_busy, err_o}, 5'b0);
    chk("rst_data", {wb_adr_o, wb_dat_o, dbus_dat_i}, 48'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios
    xfer(16'h0123, 16'h0000, 0, 0, 3, 0, 0, 16'hBEEF);
    xfer(16'h4000, 16'h5A5A, 1, 0, 1, 0, 0, 16'h1234);
    xfer(16'h0200, 16'h0000, 0, 0, 2, 1, 0, 16'h7777);
    clr_pulse();
    xfer(16'h0300, 16'h0000, 0, 0, 9, 0, 0, 16'h5555);
    clr_pulse();
    xfer(16'h0400, 16'hC0DE, 1, 0, 3, 0, 2, 16'h0000);
    clr_pulse();
    xfer(16'h0500, 16'hAAAA, 0, 1, 2, 0, 0, 16'h0000);
    clr_pulse();
    xfer(16'h0600, 16'h0000, 0, 0, 2, 0, 0, 16'h3C3C);

    // Reset in the 2nd BUS cycle with a late ack and a strobe during reset
    dbus_adr = 16'h1111; dbus_re = 1'b1;
    @(posedge clk); #1; dbus_re = 1'b0;
    @(negedge clk); chk("rb_cyc1", wb_cyc_o, 1'b1);
    @(negedge clk); chk("rb_cyc2", wb_cyc_o, 1'b1);
    reset = 1'b1; dbus_we = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; dbus_we = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 16'h9999;
    @(negedge clk);
    chk("rb_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, dbus_busy, err_o}, 5'b0);
    chk("rb_data", {wb_adr_o, wb_dat_o, dbus_dat_i}, 48'h0);
    @(posedge clk); #1; wb_ack_i = 1'b0;
    @(negedge clk);
    chk("rb_late_ack", {wb_cyc_o, dbus_dat_i}, 17'h0);
    err_m = 1'b0; rdat_m = '0;
    $display("reset abort cyc=%0d rdat=%h err_o=%0d", wb_cyc_o, dbus_dat_i, err_o);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) clr_pulse();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), int'($urandom_range(1, 6)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0,
           16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
